// File: rtl/ship_move_ctrl.sv
// Player-ship X movement controller: arbitrates push-buttons and mouse deltas
// into single-cycle Sm/Rs strobes for the position counter, clamped to the playfield.
module ship_move_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int POS_MIN  = 16,
  parameter int POS_MAX  = 600
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        ms_valid,
  input  logic [8:0]  ms_dx,
  output logic        ms_ready,
  input  logic [10:0] pos,
  output logic        Sm,
  output logic        Rs,
  output logic        busy,
  output logic        src
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, BTN, M_STEP, M_WAIT} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [8:0]    pend_mag_reg, pend_mag_next;
  logic          pend_dir_reg, pend_dir_next;
  logic          btn_dir_reg, btn_dir_next;
  logic          sm_reg, sm_next;
  logic          rs_reg, rs_next;
  logic          src_reg, src_next;

  logic       cmd;
  logic       right_ok;
  logic       left_ok;
  logic       accept;
  logic [8:0] dx_mag;

  assign cmd      = btn_l ^ btn_r;
  assign right_ok = (pos < 11'(POS_MAX));
  assign left_ok  = (pos > 11'(POS_MIN));
  assign ms_ready = (pend_mag_reg == 9'd0) && (state_reg != M_STEP) && (state_reg != M_WAIT);
  assign accept   = ms_valid && ms_ready;
  // -256 negates to 9'h100, which is the correct unsigned magnitude
  assign dx_mag   = ms_dx[8] ? (~ms_dx + 9'd1) : ms_dx;

  assign Sm   = sm_reg;
  assign Rs   = rs_reg;
  assign src  = src_reg;
  assign busy = (state_reg != IDLE);

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      pend_mag_reg <= '0;
      pend_dir_reg <= 1'b0;
      btn_dir_reg  <= 1'b0;
      sm_reg       <= 1'b0;
      rs_reg       <= 1'b0;
      src_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      pend_mag_reg <= pend_mag_next;
      pend_dir_reg <= pend_dir_next;
      btn_dir_reg  <= btn_dir_next;
      sm_reg       <= sm_next;
      rs_reg       <= rs_next;
      src_reg      <= src_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    presc_next    = presc_reg;
    pend_mag_next = pend_mag_reg;
    pend_dir_next = pend_dir_reg;
    btn_dir_next  = btn_dir_reg;
    sm_next       = 1'b0;
    rs_next       = 1'b0;
    src_next      = src_reg;

    if (accept) begin
      pend_mag_next = dx_mag;
      pend_dir_next = ~ms_dx[8];
    end

    case (state_reg)
      IDLE: begin
        if (cmd) begin
          state_next   = BTN;
          presc_next   = '0;
          btn_dir_next = btn_r;
          if (btn_r && right_ok) begin
            sm_next  = 1'b1;
            src_next = 1'b0;
          end else if (!btn_r && left_ok) begin
            rs_next  = 1'b1;
            src_next = 1'b0;
          end
        end else if (pend_mag_reg != 9'd0) begin
          state_next = M_STEP;
        end
      end
      BTN: begin
        // A direction flip drops to IDLE so the new direction restarts its cadence
        if (!cmd || (btn_r != btn_dir_reg)) begin
          state_next = IDLE;
        end else if (presc_reg == PW'(TICK_DIV - 1)) begin
          presc_next = '0;
          if (btn_dir_reg && right_ok) begin
            sm_next  = 1'b1;
            src_next = 1'b0;
          end else if (!btn_dir_reg && left_ok) begin
            rs_next  = 1'b1;
            src_next = 1'b0;
          end
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end
      M_STEP: begin
        if (pend_dir_reg ? right_ok : left_ok) begin
          sm_next       = pend_dir_reg;
          rs_next       = ~pend_dir_reg;
          src_next      = 1'b1;
          pend_mag_next = pend_mag_reg - 9'd1;
          state_next    = M_WAIT;
        end else begin
          pend_mag_next = '0;
          state_next    = IDLE;
        end
      end
      M_WAIT: begin
        state_next = (pend_mag_reg != 9'd0) ? M_STEP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ship_move_ctrl.sv
// Closed-loop bench for ship_move_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-level behavioural model.
module tb_ship_move_ctrl;

  localparam int TICK_DIV = 4;
  localparam int POS_MIN  = 16;
  localparam int POS_MAX  = 600;
  localparam int POS_RST  = 228;

  logic        CLK = 1'b0;
  logic        Rst;
  logic        btn_l, btn_r;
  logic        ms_valid;
  logic [8:0]  ms_dx;
  logic        ms_ready;
  logic [10:0] pos;
  logic        Sm, Rs, busy, src;
  logic        load_en;
  logic [10:0] load_val;

  int n_tests = 0;
  int n_fail  = 0;
  int sm_cnt  = 0;
  int rs_cnt  = 0;

  always #5 CLK = ~CLK;

  // Position counter in the loop, with a load port for placing the ship
  always_ff @(posedge CLK) begin
    if (Rst)          pos <= 11'(POS_RST);
    else if (load_en) pos <= load_val;
    else if (Sm)      pos <= pos + 11'd1;
    else if (Rs)      pos <= pos - 11'd1;
  end

  ship_move_ctrl #(.TICK_DIV(TICK_DIV), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)) dut (
    .CLK(CLK), .Rst(Rst), .btn_l(btn_l), .btn_r(btn_r),
    .ms_valid(ms_valid), .ms_dx(ms_dx), .ms_ready(ms_ready),
    .pos(pos), .Sm(Sm), .Rs(Rs), .busy(busy), .src(src)
  );

  // Model: mode 0 = idle, 1 = button hold, 2 = mouse burst
  int m_mode = 0;
  int m_bdir = 0;
  int m_age = 0;
  int m_pend = 0;
  int m_pright = 0;
  int m_t = 0;
  bit e_sm = 0, e_rs = 0, e_src = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit allowed(input bit right);
    return right ? (int'(pos) < POS_MAX) : (int'(pos) > POS_MIN);
  endfunction

  task automatic try_step(input bit right, input bit s);
    if (allowed(right)) begin
      if (right) e_sm = 1'b1;
      else       e_rs = 1'b1;
      e_src = s;
    end
  endtask

  // Predicts the effect of the coming rising edge from the current inputs and pos
  task automatic model_step();
    bit ready, cmd, right;
    int dx;
    e_sm = 1'b0;
    e_rs = 1'b0;
    if (Rst) begin
      m_mode = 0; m_pend = 0; e_src = 1'b0;
      return;
    end
    ready = (m_pend == 0) && (m_mode != 2);
    cmd   = btn_l ^ btn_r;
    right = btn_r;
    case (m_mode)
      0: begin
        if (cmd) begin
          m_mode = 1; m_bdir = right; m_age = 0;
          try_step(right, 1'b0);
        end else if (m_pend != 0) begin
          m_mode = 2; m_t = 0;
        end
      end
      1: begin
        if (!cmd || (int'(right) != m_bdir)) m_mode = 0;
        else begin
          m_age++;
          if (m_age % TICK_DIV == 0) try_step(right, 1'b0);
        end
      end
      default: begin
        if (m_t % 2 == 0) begin
          if (allowed(m_pright != 0)) begin
            try_step(m_pright != 0, 1'b1);
            m_pend--;
            m_t++;
          end else begin
            m_pend = 0; m_mode = 0;
          end
        end else if (m_pend != 0) m_t++;
        else m_mode = 0;
      end
    endcase
    if (ms_valid && ready) begin
      dx = int'($signed(ms_dx));
      m_pend   = (dx < 0) ? -dx : dx;
      m_pright = (dx > 0) ? 1 : 0;
      $display("[TB] t=%0t mouse delta accepted dx=%0d pos=%0d", $time, dx, pos);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_val("Sm", Sm, e_sm);
    check_val("Rs", Rs, e_rs);
    check_val("src", src, e_src);
    check_val("busy", busy, (m_mode != 0));
    check_val("ms_ready", ms_ready, (m_pend == 0) && (m_mode != 2));
    if (Sm) sm_cnt++;
    if (Rs) rs_cnt++;
  endtask

  task automatic do_reset();
    Rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; ms_valid = 1'b0; load_en = 1'b0;
    cycle();
    Rst = 1'b0;
    sm_cnt = 0; rs_cnt = 0;
  endtask

  task automatic offer(input int dx);
    ms_valid = 1'b1;
    ms_dx = 9'(dx);
    cycle();
    ms_valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; ms_valid = 1'b0; ms_dx = '0;
    load_en = 1'b0; load_val = '0;
    @(negedge CLK);
    do_reset();
    check_val("reset_pos", pos, POS_RST);

    // Button hold right for 13 cycles
    btn_r = 1'b1;
    for (int i = 0; i < 13; i++) cycle();
    btn_r = 1'b0;
    cycle();
    check_val("s1_sm_count", sm_cnt, 4);
    check_val("s1_rs_count", rs_cnt, 0);
    check_val("s1_pos", pos, 232);
    $display("[TB] scenario btn_r hold: %0d Sm pulses, pos=%0d", sm_cnt, pos);

    // Mouse dx = -5
    do_reset();
    offer(-5);
    for (int i = 0; i < 14; i++) cycle();
    check_val("s2_rs_count", rs_cnt, 5);
    check_val("s2_pos", pos, 223);
    check_val("s2_src", src, 1);
    $display("[TB] scenario dx=-5: %0d Rs pulses, pos=%0d", rs_cnt, pos);

    // Right bound clamp from 598
    load_en = 1'b1; load_val = 11'd598;
    cycle();
    load_en = 1'b0;
    check_val("s3_load", pos, 598);
    sm_cnt = 0; rs_cnt = 0;
    offer(10);
    for (int i = 0; i < 30; i++) cycle();
    check_val("s3_sm_count", sm_cnt, 2);
    check_val("s3_pos", pos, 600);
    check_val("s3_ready", ms_ready, 1);
    $display("[TB] scenario clamp: %0d Sm pulses, pos=%0d", sm_cnt, pos);

    // Both buttons held with pending mouse delta, then btn_l alone mid-burst
    do_reset();
    btn_l = 1'b1; btn_r = 1'b1;
    offer(3);
    for (int i = 0; i < 3; i++) cycle();
    btn_r = 1'b0;
    for (int i = 0; i < 17; i++) cycle();
    btn_l = 1'b0;
    check_val("s4_sm_count", sm_cnt, 3);
    check_val("s4_rs_count", rs_cnt, 4);
    cycle();
    $display("[TB] scenario arbitration: %0d Sm, %0d Rs", sm_cnt, rs_cnt);

    // Zero delta, then an immediate second delta
    do_reset();
    offer(0);
    check_val("s5_zero_ready", ms_ready, 1);
    offer(2);
    check_val("s5_second_accept", ms_ready, 0);
    for (int i = 0; i < 6; i++) cycle();
    check_val("s5_sm_count", sm_cnt, 2);
    $display("[TB] scenario zero delta: %0d Sm pulses", sm_cnt);

    // Reset in the middle of a 20-step burst
    do_reset();
    offer(20);
    for (int i = 0; i < 100 && sm_cnt < 6; i++) cycle();
    check_val("s6_strobes_before_rst", sm_cnt, 6);
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
    check_val("s6_sm", Sm, 0);
    check_val("s6_ready", ms_ready, 1);
    check_val("s6_pos", pos, POS_RST);
    sm_cnt = 0;
    for (int i = 0; i < 6; i++) cycle();
    check_val("s6_no_more_sm", sm_cnt, 0);
    $display("[TB] scenario reset mid-burst: pos=%0d", pos);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) {btn_l, btn_r} = 2'($urandom_range(3));
      ms_valid = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) ms_dx = 9'($urandom_range(511));
      else                        ms_dx = 9'($urandom_range(16)) - 9'd8;
      load_en = ($urandom_range(199) == 0);
      case ($urandom_range(2))
        0:       load_val = 11'($urandom_range(24, 10));
        1:       load_val = 11'($urandom_range(606, 594));
        default: load_val = 11'($urandom_range(700));
      endcase
      Rst = ($urandom_range(499) == 0);
      cycle();
    end
    Rst = 1'b0; ms_valid = 1'b0; load_en = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
